cg_enable_ctrl: RTL and testbench

- Produces the enable for the team's latch-based clock gate (`dual_latch`), so it drives the gate's `en` input.
- Watches downstream activity and wake requests.
- Drops the enable after a programmable idle window, with a one-cycle drain handshake.
- Restores the enable on demand, then holds `ready` low for a warm-up window before the gated domain is declared usable.
- Runs entirely on the free-running (ungated) clock.

---
 rtl/cg_enable_ctrl.sv | 147 ++++++++++++++
 tb/tb_cg_enable_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cg_enable_ctrl.sv
// cg_enable_ctrl: enable generator for the dual_latch clock gate.
// Watches downstream activity and wake requests, drops the gate enable after
// IDLE_CYCLES idle cycles (with a one-cycle DRAIN handshake), and restores it
// on demand, holding `ready` low for WAKE_CYCLES while the domain warms up.
// Runs on the free-running clock; every output is a flop.
//
// Optional feature: define CG_STATS_EN to build the saturating gated-cycle
// statistics counter. Without it `gated_cycles` is tied to zero.
module cg_enable_ctrl #(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             wake_req,
    input  logic             force_on,
    input  logic             stats_clr,
    output logic             gate_en,
    output logic             ready,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] gated_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_t;

    localparam int IDLE_W = $clog2(IDLE_CYCLES) + 1;
    localparam int WAKE_W = $clog2(WAKE_CYCLES) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic                gate_en_q, gate_en_d;
    logic                ready_q, ready_d;
    logic                active;

    // force_on and busy are deliberately indistinguishable here.
    assign active = busy | wake_req | force_on;

    // State register: FSM state, counters and the registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_en_q  <= 1'b1;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            gate_en_q  <= gate_en_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic: idle detection, drain handshake and wake warm-up.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        idle_cnt_d = '0;           // idle count only survives while in RUN
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            RUN: begin
                if (active) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d = DRAIN;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // Last chance to abort before the clock actually stops.
                state_d = active ? RUN : GATED;
            end
            GATED: begin
                if (active) begin
                    state_d    = WAKE;
                    wake_cnt_d = WAKE_LOAD;
                end
            end
            WAKE: begin
                // Inputs are ignored: the warm-up always runs to completion.
                if (wake_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Output decode from the next state, so the outputs register alongside it
    // and gate_en can only change on a rising edge.
    always_comb begin
        gate_en_d = (state_d != GATED);
        ready_d   = (state_d == RUN);
    end

    assign gate_en = gate_en_q;
    assign ready   = ready_q;
    assign state_o = state_q;

`ifdef CG_STATS_EN
    logic [CNT_W-1:0] gated_cycles_q, gated_cycles_d;

    // Statistics next value: clear beats increment; increment saturates.
    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if (stats_clr) begin
            gated_cycles_d = '0;
        end else if ((state_q == GATED) && (gated_cycles_q != '1)) begin
            gated_cycles_d = gated_cycles_q + 1'b1;
        end
    end

    // Statistics register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gated_cycles_q <= '0;
        end else begin
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign gated_cycles = gated_cycles_q;
`else
    // Feature disabled: constant output, clear input has no effect.
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign gated_cycles     = '0;
`endif

endmodule

// File: tb/tb_cg_enable_ctrl.sv
// Directed bench for cg_enable_ctrl (IDLE_CYCLES=8, WAKE_CYCLES=2, CNT_W=4).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// following rising edge. Expected gated_cycles depends on CG_STATS_EN.
module tb_cg_enable_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, busy, wake_req, force_on, stats_clr;
    logic             gate_en, ready;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] gated_cycles;

    int checks = 0;
    int errors = 0;

    cg_enable_ctrl #(
        .IDLE_CYCLES(8),
        .WAKE_CYCLES(2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .busy        (busy),
        .wake_req    (wake_req),
        .force_on    (force_on),
        .stats_clr   (stats_clr),
        .gate_en     (gate_en),
        .ready       (ready),
        .state_o     (state_o),
        .gated_cycles(gated_cycles)
    );

    always #5 clk = ~clk;

    // Drive one set of inputs and advance past the next rising edge.
    task automatic step(input logic r, input logic b, input logic w,
                        input logic f, input logic c);
        rst = r; busy = b; wake_req = w; force_on = f; stats_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] st,
                             input logic ge, input logic rdy);
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".gate_en"}, 32'(gate_en), 32'(ge));
        check({tag, ".ready"}, 32'(ready), 32'(rdy));
    endtask

    // Expected statistics value after n gated edges since the last clear.
    function automatic logic [31:0] exp_gc(input int n);
`ifdef CG_STATS_EN
        return (n > 15) ? 32'd15 : 32'(n);
`else
        return (n < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    initial begin
        // Reset for two edges.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_out("reset", 2'd0, 1'b1, 1'b1);
        check("reset.gc", 32'(gated_cycles), exp_gc(0));

        // Idle entry: edges 1..7 stay RUN, edge 8 DRAIN, edge 9 GATED.
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 0, 0, 0);
            check_out("idle_run", 2'd0, 1'b1, 1'b1);
        end
        step(0, 0, 0, 0, 0);
        check_out("idle_e8", 2'd1, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0);
        check_out("idle_e9", 2'd2, 1'b0, 1'b0);
        check("gated_entry.gc", 32'(gated_cycles), exp_gc(0));

        // Stay gated 5 edges.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        check_out("gated_hold", 2'd2, 1'b0, 1'b0);
        check("gated_hold.gc", 32'(gated_cycles), exp_gc(5));

        // Wake pulse on edge w; busy during WAKE has no effect.
        step(0, 0, 1, 0, 0);
        check_out("wake_w", 2'd3, 1'b1, 1'b0);
        check("wake_w.gc", 32'(gated_cycles), exp_gc(6));
        step(0, 1, 0, 0, 0);
        check_out("wake_w1", 2'd3, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0);
        check_out("wake_w2", 2'd0, 1'b1, 1'b1);
        check("wake_w2.gc", 32'(gated_cycles), exp_gc(6));

        // Abort in DRAIN, then a full fresh idle window is needed.
        for (int i = 1; i <= 7; i++) step(0, 0, 0, 0, 0);
        check_out("abort_e7", 2'd0, 1'b1, 1'b1);
        step(0, 0, 0, 0, 0);
        check_out("abort_e8", 2'd1, 1'b1, 1'b0);
        step(0, 1, 0, 0, 0);
        check_out("abort_e9", 2'd0, 1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            step(0, 0, 0, 0, 0);
            check_out("abort_rerun", 2'd0, 1'b1, 1'b1);
        end
        step(0, 0, 0, 0, 0);
        check_out("abort_drain2", 2'd1, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0);
        check_out("abort_gated2", 2'd2, 1'b0, 1'b0);

        // force_on in GATED behaves like wake_req.
        step(0, 0, 0, 1, 0);
        check_out("force_w", 2'd3, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0);
        check_out("force_w1", 2'd3, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0);
        check_out("force_w2", 2'd0, 1'b1, 1'b1);
        check("force.gc", 32'(gated_cycles), exp_gc(7));

        // Reset mid-GATED.
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_out("pre_rst_gated", 2'd2, 1'b0, 1'b0);
        check("pre_rst_gated.gc", 32'(gated_cycles), exp_gc(9));
        step(1, 0, 0, 0, 0);
        check_out("rst_gated", 2'd0, 1'b1, 1'b1);
        check("rst_gated.gc", 32'(gated_cycles), exp_gc(0));

        // Reset mid-WAKE; reset overrides the active inputs.
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check_out("pre_rst_wake", 2'd3, 1'b1, 1'b0);
        step(1, 1, 1, 1, 0);
        check_out("rst_wake", 2'd0, 1'b1, 1'b1);
        check("rst_wake.gc", 32'(gated_cycles), exp_gc(0));

        // Hold-off: busy alternates every 4 cycles, never 8 idle in a row.
        for (int i = 0; i < 40; i++) begin
            step(0, ((i / 4) % 2) == 1, 0, 0, 0);
            check("holdoff.gate_en", 32'(gate_en), 32'd1);
        end

        // Statistics saturation over 20 gated edges.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
        check_out("stats_gated", 2'd2, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, 0, 0);
            if (i == 14 || i == 15 || i == 20)
                check("stats_sat.gc", 32'(gated_cycles), exp_gc(i));
        end
        // Clear wins over increment, then counting resumes.
        step(0, 0, 0, 0, 1);
        check("stats_clr.gc", 32'(gated_cycles), exp_gc(0));
        step(0, 0, 0, 0, 0);
        check("stats_resume1.gc", 32'(gated_cycles), exp_gc(1));
        step(0, 0, 0, 0, 0);
        check("stats_resume2.gc", 32'(gated_cycles), exp_gc(2));
        check_out("stats_end", 2'd2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
